m_ghost_engine: RTL and testbench
=================================

# m_ghost_engine

Parametrised ghost update and collision engine for the Pac-Man game logic FSM. It replaces the fixed three-ghost update path and the separate ghost-collision step. On each `enable` request it walks NUM_GHOSTS ghosts through one shared path ROM port, one ghost at a time. It then checks every ghost against the player and signals completion with a one-cycle `finished` pulse, reporting a collision flag and the index of the ghost that was hit.

## Interface
- NUM_GHOSTS, 3: number of ghosts, 1..8.
- STEPW, 7: width of the per-ghost path step counter.
- PATH_LAST, {7'd50,7'd78,7'd63}: packed vector; ghost i's last valid step is at bits [i*STEPW +: STEPW].
- IDXW, derived as $clog2(NUM_GHOSTS) with a minimum of 1: ghost index width.
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- enable  in  1  request one update pass; sampled only in IDLE.
- finished  out  1  one-cycle pulse when the pass completes.
- player_x  in  5  player column.
- player_y  in  4  player row.
- path_addr  out  IDXW+STEPW  registered ROM address, formed as {ghost index, step}.
- path_q  in  11  ROM word; x is [10:6], y is [5:2], bits [1:0] are ignored.
- ghost_x  out  5*NUM_GHOSTS  ghost columns; ghost i is at [5i +: 5].
- ghost_y  out  4*NUM_GHOSTS  ghost rows; ghost i is at [4i +: 4].
- ghost_collision  out  1  the player shares a cell with at least one ghost.
- hit_index  out  IDXW  lowest index of a colliding ghost; 0 when there is no collision.

## Operation
- States: IDLE, ADVANCE, WAIT, STORE, CHECK, DONE. A ghost counter `g` selects the ghost currently being processed.
- **IDLE:** if `enable` is high, set g=0 and go to ADVANCE. Otherwise stay in IDLE.
- **ADVANCE:** compute the next step for ghost g and register it into `step[g]`. Also register `path_addr` = {g, next step}. Go to WAIT.
- **WAIT:** hold `path_addr` stable so the ROM can latch it. Go to STORE.
- **STORE:** capture `path_q` into ghost g's x and y. If g == NUM_GHOSTS-1, go to CHECK; otherwise increment g and go to ADVANCE.
- **CHECK:** compare all ghost positions against `player_x`/`player_y` in parallel.
  - Register `ghost_collision`.
  - Register `hit_index` as the lowest matching index.
  - Go to DONE.
- **DONE:** `finished`=1 for this cycle only. Then go to IDLE unconditionally.
- **Step rule (default):** if step == last, the next step is 0; otherwise step+1.
- **PATH_LAST=0:** the ghost stays at step 0 and re-reads address {i,0} on every pass.
- **Ignored enable:** `enable` while busy (any state other than IDLE) has no effect, and requests are not queued.
- **Held outputs:** `ghost_collision` and `hit_index` keep their values until the next CHECK.
- **Held positions:** `ghost_x` and `ghost_y` keep their values outside STORE.
- **Player sampling:** player inputs are sampled only in CHECK.

## Timing
- **Reset values:** all outputs are 0, and so are every step, every direction bit, `g`, and `path_addr`. The state is IDLE.
- **Reset mid-operation:** takes effect immediately and asynchronously. No `finished` pulse is issued for the aborted pass.
- **Latency:** `enable` is sampled at edge k. `finished` is high during the cycle that starts at edge k+3·NUM_GHOSTS+2.
- **Back-to-back passes:** with `enable` held high, `finished` pulses every 3·NUM_GHOSTS+3 cycles.
- **ROM contract:** `path_addr` is latched by the ROM at the end of WAIT. `path_q` must be valid throughout STORE. This is one registered-address read cycle.
- **Visibility:** the updated position of ghost i becomes visible on the outputs at the edge that ends its STORE.

## Configuration
- **GHOST_PINGPONG_EN defined:** each ghost has a direction bit that resets to forward.
  - Forward: advance by +1; at `last`, flip to reverse and move to last-1.
  - Reverse: advance by -1; at 0, flip to forward and move to 1.
  - If last == 0, the ghost stays at step 0.
- **GHOST_PINGPONG_EN undefined:** no direction state is instantiated and the wrap-to-0 rule applies.

## Structure
- Package `m_game_pkg` holds:
  - coordinate widths: X_W=5 and Y_W=4;
  - ROM field bounds: X_HI=10, X_LO=6, Y_HI=5, Y_LO=2;
  - the engine state enum.
- One sub-module, `m_ghost_step`, is a combinational next-step/next-direction function of (step, dir, last).
  - It is instantiated once and muxed by `g`.
  - Its pingpong logic is guarded by the same macro.

## Test plan
- **Reset:** with `resetn` low mid-pass (in WAIT), all outputs go to 0 immediately. After release, the first pass reads address {0,1}.
- **Latency:** NUM_GHOSTS=3 with a ROM model returning x=step, y=index. After one `enable`, `finished` pulses exactly 11 cycles after the sampling edge, with ghost x = {1,1,1} and y = {0,1,2}.
- **Wrap:** PATH_LAST for ghost 0 set to 3. Over passes 1..5, ghost 0's step is 1,2,3,0,1 without the macro and 1,2,3,2,1 with GHOST_PINGPONG_EN.
- **Collision:** player at (5,3), with the ROM placing ghosts 1 and 2 at (5,3) and ghost 0 at (0,0). Expect `ghost_collision`=1 and `hit_index`=1; a following non-matching pass clears both to 0.
- **Back-to-back and ignored enable:** hold `enable` high, and also pulse it during STORE. Expect `finished` every 12 cycles (NUM_GHOSTS=3), with no extra pass started.
- **Degenerate path:** NUM_GHOSTS=1 with PATH_LAST=0. `path_addr` stays 0, `finished` pulses 5 cycles after `enable`, and the position never changes.

Source files
------------

// File: rtl/m_game_pkg.sv
// Shared game-logic types: coordinate widths, path ROM field bounds
// and the ghost engine state encoding.
package m_game_pkg;

    localparam int X_W  = 5;
    localparam int Y_W  = 4;

    localparam int X_HI = 10;
    localparam int X_LO = 6;
    localparam int Y_HI = 5;
    localparam int Y_LO = 2;

    typedef enum logic [2:0] {
        IDLE,
        ADVANCE,
        WAIT,
        STORE,
        CHECK,
        DONE
    } eng_state_t;

endpackage

// File: rtl/m_ghost_step.sv
// Combinational next-step function for one ghost path counter.
// Bouncing (ping-pong) paths are built when GHOST_PINGPONG_EN is defined.
module m_ghost_step #(
    parameter int STEPW = 7
) (
    input  logic [STEPW-1:0] step,
    input  logic [STEPW-1:0] last,
`ifdef GHOST_PINGPONG_EN
    input  logic             dir,
    output logic             next_dir,
`endif
    output logic [STEPW-1:0] next_step
);

    localparam logic [STEPW-1:0] ONE = STEPW'(1);

`ifdef GHOST_PINGPONG_EN
    // dir 0 walks forward, dir 1 walks back toward step 0
    always_comb begin
        next_step = step;
        next_dir  = dir;
        if (last == '0) begin
            next_step = '0;
            next_dir  = 1'b0;
        end else if (!dir) begin
            if (step == last) begin
                next_step = last - ONE;
                next_dir  = 1'b1;
            end else begin
                next_step = step + ONE;
            end
        end else begin
            if (step == '0) begin
                next_step = ONE;
                next_dir  = 1'b0;
            end else begin
                next_step = step - ONE;
            end
        end
    end
`else
    assign next_step = (step == last) ? '0 : step + ONE;
`endif

endmodule

// File: rtl/m_ghost_engine.sv
// Sequential ghost update over a shared path ROM, then a parallel
// player collision check. GHOST_PINGPONG_EN selects bouncing paths.
module m_ghost_engine
    import m_game_pkg::*;
#(
    parameter int                          NUM_GHOSTS = 3,
    parameter int                          STEPW      = 7,
    parameter logic [NUM_GHOSTS*STEPW-1:0] PATH_LAST  = {7'd50, 7'd78, 7'd63},
    parameter int                          IDXW       =
        (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic                        enable,
    output logic                        finished,
    input  logic [X_W-1:0]              player_x,
    input  logic [Y_W-1:0]              player_y,
    output logic [IDXW+STEPW-1:0]       path_addr,
    input  logic [10:0]                 path_q,
    output logic [X_W*NUM_GHOSTS-1:0]   ghost_x,
    output logic [Y_W*NUM_GHOSTS-1:0]   ghost_y,
    output logic                        ghost_collision,
    output logic [IDXW-1:0]             hit_index
);

    localparam logic [IDXW-1:0] G_LAST = IDXW'(NUM_GHOSTS - 1);
    localparam logic [IDXW-1:0] G_ONE  = IDXW'(1);

    eng_state_t                  state;
    eng_state_t                  state_nx;
    logic [IDXW-1:0]             g;
    logic [NUM_GHOSTS*STEPW-1:0] steps;
    logic [STEPW-1:0]            cur_step;
    logic [STEPW-1:0]            cur_last;
    logic [STEPW-1:0]            nx_step;
    logic                        hit_any;
    logic [IDXW-1:0]             hit_idx;
    logic                        unused_q;

    assign unused_q = ^path_q[1:0];
    assign cur_step = steps[g*STEPW +: STEPW];
    assign cur_last = PATH_LAST[g*STEPW +: STEPW];

`ifdef GHOST_PINGPONG_EN
    logic [NUM_GHOSTS-1:0] dirs;
    logic                  nx_dir;

    m_ghost_step #(
        .STEPW     (STEPW)
    ) u_step (
        .step      (cur_step),
        .last      (cur_last),
        .dir       (dirs[g]),
        .next_dir  (nx_dir),
        .next_step (nx_step)
    );
`else
    m_ghost_step #(
        .STEPW     (STEPW)
    ) u_step (
        .step      (cur_step),
        .last      (cur_last),
        .next_step (nx_step)
    );
`endif

    // Descending scan so the lowest matching ghost wins
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NUM_GHOSTS - 1; i >= 0; i--) begin
            if (ghost_x[i*X_W +: X_W] == player_x &&
                ghost_y[i*Y_W +: Y_W] == player_y) begin
                hit_any = 1'b1;
                hit_idx = IDXW'(i);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (enable) state_nx = ADVANCE;
            ADVANCE: state_nx = WAIT;
            WAIT:    state_nx = STORE;
            STORE:   state_nx = (g == G_LAST) ? CHECK : ADVANCE;
            CHECK:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // finished is registered off DONE, so it is seen one cycle later
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            g               <= '0;
            steps           <= '0;
            path_addr       <= '0;
            ghost_x         <= '0;
            ghost_y         <= '0;
            ghost_collision <= 1'b0;
            hit_index       <= '0;
            finished        <= 1'b0;
`ifdef GHOST_PINGPONG_EN
            dirs            <= '0;
`endif
        end else begin
            finished <= (state == DONE);
            unique case (state)
                IDLE: begin
                    if (enable) g <= '0;
                end
                ADVANCE: begin
                    steps[g*STEPW +: STEPW] <= nx_step;
                    path_addr               <= {g, nx_step};
`ifdef GHOST_PINGPONG_EN
                    dirs[g]                 <= nx_dir;
`endif
                end
                STORE: begin
                    ghost_x[g*X_W +: X_W] <= path_q[X_HI:X_LO];
                    ghost_y[g*Y_W +: Y_W] <= path_q[Y_HI:Y_LO];
                    if (g != G_LAST) g <= g + G_ONE;
                end
                CHECK: begin
                    ghost_collision <= hit_any;
                    hit_index       <= hit_idx;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_m_ghost_engine.sv
// Directed bench for m_ghost_engine: a three-ghost instance and a
// single-ghost instance with a degenerate path, each fed by a ROM model.
module tb_m_ghost_engine;

    logic        clock   = 1'b0;
    logic        resetn  = 1'b0;
    logic        enable  = 1'b0;
    logic        enable1 = 1'b0;
    logic [4:0]  player_x = '0;
    logic [3:0]  player_y = '0;

    logic        finished;
    logic [8:0]  path_addr;
    logic [10:0] path_q;
    logic [14:0] ghost_x;
    logic [11:0] ghost_y;
    logic        ghost_collision;
    logic [1:0]  hit_index;

    logic        finished1;
    logic [7:0]  path_addr1;
    logic [10:0] path_q1;
    logic [4:0]  ghost_x1;
    logic [3:0]  ghost_y1;
    logic        ghost_collision1;
    logic [0:0]  hit_index1;

    int n_cmp = 0;
    int n_bad = 0;
    int rom_mode = 0;

    logic [8:0] rom_a  = '0;
    logic [7:0] rom_a1 = '0;

    always #5 clock = ~clock;

    m_ghost_engine #(
        .NUM_GHOSTS (3),
        .STEPW      (7),
        .PATH_LAST  ({7'd50, 7'd78, 7'd3})
    ) dut (
        .clock           (clock),
        .resetn          (resetn),
        .enable          (enable),
        .finished        (finished),
        .player_x        (player_x),
        .player_y        (player_y),
        .path_addr       (path_addr),
        .path_q          (path_q),
        .ghost_x         (ghost_x),
        .ghost_y         (ghost_y),
        .ghost_collision (ghost_collision),
        .hit_index       (hit_index)
    );

    m_ghost_engine #(
        .NUM_GHOSTS (1),
        .STEPW      (7),
        .PATH_LAST  (7'd0)
    ) dut1 (
        .clock           (clock),
        .resetn          (resetn),
        .enable          (enable1),
        .finished        (finished1),
        .player_x        (player_x),
        .player_y        (player_y),
        .path_addr       (path_addr1),
        .path_q          (path_q1),
        .ghost_x         (ghost_x1),
        .ghost_y         (ghost_y1),
        .ghost_collision (ghost_collision1),
        .hit_index       (hit_index1)
    );

    function automatic logic [10:0] rom_word(input logic [8:0] a, input int mode);
        logic [1:0] idx;
        logic [4:0] x;
        logic [3:0] y;
        idx = a[8:7];
        x   = a[4:0];
        y   = {2'b00, idx};
        case (mode)
            1: if (idx == 2'd0) begin x = 5'd0; y = 4'd0; end
               else begin x = 5'd5; y = 4'd3; end
            2: if (idx == 2'd2) begin x = 5'd5; y = 4'd3; end
               else begin x = 5'd7; y = 4'd7; end
            3: begin x = 5'd9; y = 4'd9; end
            default: ;
        endcase
        return {x, y, 2'b11};
    endfunction

    // Registered-address ROMs: address latched at the end of WAIT
    always @(posedge clock) begin
        rom_a  <= path_addr;
        rom_a1 <= path_addr1;
    end

    always @* path_q  = rom_word(rom_a, rom_mode);
    always @* path_q1 = {5'd6 + rom_a1[4:0], 4'd9, 2'b01};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    // Start one pass and return edges from the sampling edge to finished
    task automatic run_pass(input bit which, output int lat);
        if (which) enable1 = 1'b1;
        else enable = 1'b1;
        tick();
        enable  = 1'b0;
        enable1 = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if ((which ? finished1 : finished) === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int lat;
        #2;
        n_cmp++; if (finished !== 1'b0) begin n_bad++; $display("FAIL rst_finished: got %0b want 0", finished); end
        n_cmp++; if (path_addr !== 9'd0) begin n_bad++; $display("FAIL rst_path_addr: got %0h want 0", path_addr); end
        n_cmp++; if (ghost_x !== 15'd0) begin n_bad++; $display("FAIL rst_ghost_x: got %0h want 0", ghost_x); end
        n_cmp++; if (ghost_y !== 12'd0) begin n_bad++; $display("FAIL rst_ghost_y: got %0h want 0", ghost_y); end
        n_cmp++; if (ghost_collision !== 1'b0) begin n_bad++; $display("FAIL rst_collision: got %0b want 0", ghost_collision); end
        n_cmp++; if (hit_index !== 2'd0) begin n_bad++; $display("FAIL rst_hit_index: got %0d want 0", hit_index); end
        tick();
        resetn = 1'b1;
        tick();
        rom_mode = 0;
        run_pass(1'b0, lat);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        n_cmp++; if (path_addr !== 9'd2) begin n_bad++; $display("FAIL rst_wait_addr: got %0h want 2", path_addr); end
        #2 resetn = 1'b0;
        #1;
        n_cmp++; if (ghost_x !== 15'd0) begin n_bad++; $display("FAIL rst_mid_ghost_x: got %0h want 0", ghost_x); end
        n_cmp++; if (ghost_y !== 12'd0) begin n_bad++; $display("FAIL rst_mid_ghost_y: got %0h want 0", ghost_y); end
        n_cmp++; if (path_addr !== 9'd0) begin n_bad++; $display("FAIL rst_mid_path_addr: got %0h want 0", path_addr); end
        tick();
        resetn = 1'b1;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        n_cmp++; if (path_addr !== 9'd1) begin n_bad++; $display("FAIL rst_first_addr: got %0h want 1", path_addr); end
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (finished === 1'b1) begin
                lat = n;
                break;
            end
        end
        n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL rst_pass_done: got %0d want 10", lat); end
    endtask

    task automatic test_latency();
        int lat;
        do_reset();
        rom_mode = 0;
        run_pass(1'b0, lat);
        n_cmp++; if (lat !== 11) begin n_bad++; $display("FAIL lat_cycles: got %0d want 11", lat); end
        n_cmp++; if (ghost_x !== {5'd1, 5'd1, 5'd1}) begin n_bad++; $display("FAIL lat_ghost_x: got %0h want %0h", ghost_x, {5'd1, 5'd1, 5'd1}); end
        n_cmp++; if (ghost_y !== {4'd2, 4'd1, 4'd0}) begin n_bad++; $display("FAIL lat_ghost_y: got %0h want %0h", ghost_y, {4'd2, 4'd1, 4'd0}); end
        tick();
        n_cmp++; if (finished !== 1'b0) begin n_bad++; $display("FAIL lat_pulse_width: got %0b want 0", finished); end
    endtask

    task automatic test_wrap();
        int lat;
`ifdef GHOST_PINGPONG_EN
        int exp0[5] = '{1, 2, 3, 2, 1};
`else
        int exp0[5] = '{1, 2, 3, 0, 1};
`endif
        do_reset();
        rom_mode = 0;
        for (int p = 0; p < 5; p++) begin
            run_pass(1'b0, lat);
            n_cmp++; if (ghost_x[4:0] !== 5'(exp0[p])) begin n_bad++; $display("FAIL wrap_g0_pass%0d: got %0d want %0d", p + 1, ghost_x[4:0], exp0[p]); end
            n_cmp++; if (ghost_x[9:5] !== 5'(p + 1)) begin n_bad++; $display("FAIL wrap_g1_pass%0d: got %0d want %0d", p + 1, ghost_x[9:5], p + 1); end
        end
    endtask

    task automatic test_collision();
        int lat;
        do_reset();
        player_x = 5'd5;
        player_y = 4'd3;
        rom_mode = 1;
        run_pass(1'b0, lat);
        n_cmp++; if (ghost_collision !== 1'b1) begin n_bad++; $display("FAIL col_flag: got %0b want 1", ghost_collision); end
        n_cmp++; if (hit_index !== 2'd1) begin n_bad++; $display("FAIL col_index: got %0d want 1", hit_index); end
        tick();
        tick();
        tick();
        n_cmp++; if (ghost_collision !== 1'b1 || hit_index !== 2'd1) begin n_bad++; $display("FAIL col_hold: got %0b/%0d want 1/1", ghost_collision, hit_index); end
        rom_mode = 2;
        run_pass(1'b0, lat);
        n_cmp++; if (ghost_collision !== 1'b1 || hit_index !== 2'd2) begin n_bad++; $display("FAIL col_ghost2: got %0b/%0d want 1/2", ghost_collision, hit_index); end
        rom_mode = 3;
        run_pass(1'b0, lat);
        n_cmp++; if (ghost_collision !== 1'b0) begin n_bad++; $display("FAIL col_clear_flag: got %0b want 0", ghost_collision); end
        n_cmp++; if (hit_index !== 2'd0) begin n_bad++; $display("FAIL col_clear_index: got %0d want 0", hit_index); end
        player_x = 5'd9;
        player_y = 4'd9;
        for (int n = 0; n < 5; n++) tick();
        n_cmp++; if (ghost_collision !== 1'b0) begin n_bad++; $display("FAIL col_player_unsampled: got %0b want 0", ghost_collision); end
        player_x = 5'd0;
        player_y = 4'd0;
    endtask

    task automatic test_back_to_back();
        int t[3];
        int k;
        int first;
        int pulses;
        do_reset();
        rom_mode = 0;
        t = '{-1, -1, -1};
        k = 0;
        enable = 1'b1;
        tick();
        for (int n = 1; n <= 60 && k < 3; n++) begin
            tick();
            if (finished === 1'b1) begin
                t[k] = n;
                k++;
                if (k == 3) enable = 1'b0;
            end
        end
        enable = 1'b0;
        n_cmp++; if (t[0] !== 11) begin n_bad++; $display("FAIL b2b_first: got %0d want 11", t[0]); end
        n_cmp++; if (t[1] - t[0] !== 12) begin n_bad++; $display("FAIL b2b_period1: got %0d want 12", t[1] - t[0]); end
        n_cmp++; if (t[2] - t[1] !== 12) begin n_bad++; $display("FAIL b2b_period2: got %0d want 12", t[2] - t[1]); end
        n_cmp++; if (ghost_x[9:5] !== 5'd3) begin n_bad++; $display("FAIL b2b_passes: got %0d want 3", ghost_x[9:5]); end
        enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        tick();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        first  = -1;
        pulses = 0;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (finished === 1'b1) begin
                pulses++;
                if (first < 0) first = n;
            end
        end
        n_cmp++; if (first !== 8) begin n_bad++; $display("FAIL ign_latency: got %0d want 8", first); end
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL ign_pulses: got %0d want 1", pulses); end
        n_cmp++; if (ghost_x[9:5] !== 5'd4) begin n_bad++; $display("FAIL ign_passes: got %0d want 4", ghost_x[9:5]); end
    endtask

    task automatic test_degenerate();
        int  lat;
        bit  addr_ok;
        do_reset();
        n_cmp++; if (ghost_x1 !== 5'd0) begin n_bad++; $display("FAIL deg_reset_x: got %0d want 0", ghost_x1); end
        for (int p = 0; p < 3; p++) begin
            addr_ok = 1'b1;
            lat     = -1;
            enable1 = 1'b1;
            tick();
            enable1 = 1'b0;
            for (int n = 1; n <= 20; n++) begin
                tick();
                if (path_addr1 !== 8'd0) addr_ok = 1'b0;
                if (finished1 === 1'b1) begin
                    lat = n;
                    break;
                end
            end
            n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL deg_latency_pass%0d: got %0d want 5", p + 1, lat); end
            n_cmp++; if (addr_ok !== 1'b1) begin n_bad++; $display("FAIL deg_addr_pass%0d: got nonzero want 0", p + 1); end
            n_cmp++; if (ghost_x1 !== 5'd6) begin n_bad++; $display("FAIL deg_x_pass%0d: got %0d want 6", p + 1, ghost_x1); end
            n_cmp++; if (ghost_y1 !== 4'd9) begin n_bad++; $display("FAIL deg_y_pass%0d: got %0d want 9", p + 1, ghost_y1); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_wrap();
        test_collision();
        test_back_to_back();
        test_degenerate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
